// File: rtl/pool_window_2x2_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pool stage.
package pool_window_2x2_pkg;

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } row_state_e;

    // Counter/address width for a range of v values; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic int unsigned half_w(input int unsigned img_w);
        return img_w / 2;
    endfunction

    // Compare-based signed max; ties return a.
    function automatic logic signed [31:0] smax(input logic signed [31:0] a,
                                                input logic signed [31:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_window_2x2_if.sv
// Input pixel stream and pooled output stream of the max-pool stage.
interface pool_window_2x2_if #(
    parameter int unsigned WIDTH = 9
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_data;
    logic                    out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/pool_window_2x2_max2.sv
// Combinational signed max of two pixels.
module pool_window_2x2_max2
    import pool_window_2x2_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y
);
    assign y = WIDTH'(smax(32'(a), 32'(b)));
endmodule

// File: rtl/pool_window_2x2.sv
// Streaming 2x2 stride-2 max-pool: horizontal pair maxima of even rows are kept
// in a half-width line buffer and merged with the odd row's pairs.
module pool_window_2x2
    import pool_window_2x2_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input logic        clk,
    input logic        rst_n,
    pool_window_2x2_if.slave io
);
    localparam int unsigned HALF_W = half_w(IMG_W);
    localparam int unsigned COL_W  = clog2(IMG_W);
    localparam int unsigned ROW_W  = clog2(IMG_H);
    localparam int unsigned ADDR_W = clog2(HALF_W);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    row_state_e              state_q, state_d;
    logic signed [WIDTH-1:0] hold_q, hold_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [WIDTH-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic signed [WIDTH-1:0] lbuf_q [HALF_W];
    logic [ADDR_W-1:0]       lbuf_addr;
    logic                    lbuf_we;
    logic signed [WIDTH-1:0] lbuf_rd;
    logic signed [WIDTH-1:0] h_max;
    logic signed [WIDTH-1:0] v_max;
    logic                    in_ready;
    logic                    accept;

    assign in_ready  = !out_valid_q || io.out_ready;
    assign accept    = io.in_valid && in_ready;
    assign lbuf_addr = ADDR_W'(col_q >> 1);
    assign lbuf_rd   = lbuf_q[lbuf_addr];

    pool_window_2x2_max2 #(.WIDTH(WIDTH)) u_hmax (.a(hold_q),  .b(io.in_data), .y(h_max));
    pool_window_2x2_max2 #(.WIDTH(WIDTH)) u_vmax (.a(lbuf_rd), .b(h_max),      .y(v_max));

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        state_d     = state_q;
        hold_d      = hold_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        lbuf_we     = 1'b0;

        // Drain first so that a load in the same cycle overrides it.
        if (out_valid_q && io.out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d   = '0;
                row_d   = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!col_q[0]) begin
                hold_d = io.in_data;
            end else if (state_q == ROW_EVEN) begin
                lbuf_we = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = v_max;
                out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            state_q     <= ROW_EVEN;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lbuf_we) lbuf_q[lbuf_addr] <= h_max;
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_last  = out_last_q;
endmodule

// File: tb/tb_pool_window_2x2.sv
// Bench for pool_window_2x2: directed 4x4 frames plus randomized 28x28 traffic,
// both checked against a frame-array reference of 2x2 window maxima.
module tb_pool_window_2x2;
    localparam int NFRAMES = 25;
    localparam int NPIX    = NFRAMES * 28 * 28;

    logic clk;
    logic rst_n;

    pool_window_2x2_if #(.WIDTH(9)) io0 ();
    pool_window_2x2_if #(.WIDTH(9)) io1 ();

    pool_window_2x2 #(.WIDTH(9), .IMG_W(4), .IMG_H(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .io(io0)
    );
    pool_window_2x2 #(.WIDTH(9), .IMG_W(28), .IMG_H(28)) dut1 (
        .clk(clk), .rst_n(rst_n), .io(io1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Reference state per DUT: pixels of the current frame, pending results.
    int pix [2][784];
    int n [2];
    int expq [2][$];
    bit lastq [2][$];
    bit lat_pend [2];
    int lat_val [2];
    int outs [2];
    int got_v [$];
    bit got_l [$];
    int want_v [$];
    bit want_l [$];

    task automatic observe(input int d, input int w, input int h, input bit acc,
                           input int din, input bit ov, input bit ordy,
                           input int dout, input bit olast);
        int r, c, m, ev;
        bit el;
        if (!rst_n) begin
            n[d] = 0;
            expq[d].delete();
            lastq[d].delete();
            lat_pend[d] = 1'b0;
            return;
        end
        if (lat_pend[d]) begin
            chk("latency_valid", int'(ov), 1);
            chk("latency_data", dout, lat_val[d]);
            lat_pend[d] = 1'b0;
        end
        if (ov && ordy) begin
            if (expq[d].size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                ev = expq[d].pop_front();
                el = lastq[d].pop_front();
                chk("out_data", dout, ev);
                chk("out_last", int'(olast), int'(el));
                outs[d]++;
            end
            if (d == 0) begin
                got_v.push_back(dout);
                got_l.push_back(olast);
            end
        end
        if (acc) begin
            r = n[d] / w;
            c = n[d] % w;
            pix[d][n[d]] = din;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                m = pix[d][(r-1)*w + c-1];
                if (pix[d][(r-1)*w + c] > m) m = pix[d][(r-1)*w + c];
                if (pix[d][r*w + c-1] > m)   m = pix[d][r*w + c-1];
                if (din > m)                 m = din;
                expq[d].push_back(m);
                lastq[d].push_back((r == h-1) && (c == w-1));
                lat_pend[d] = 1'b1;
                lat_val[d]  = m;
            end
            n[d] = (n[d] + 1) % (w * h);
        end
    endtask

    always @(negedge clk) begin
        observe(0, 4, 4, io0.in_valid && io0.in_ready, int'(io0.in_data), io0.out_valid,
                io0.out_ready, int'(io0.out_data), io0.out_last);
        observe(1, 28, 28, io1.in_valid && io1.in_ready, int'(io1.in_data), io1.out_valid,
                io1.out_ready, int'(io1.out_data), io1.out_last);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input int v);
        bit acc;
        io0.in_valid = 1'b1;
        io0.in_data  = 9'(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = io0.in_ready;
            cycle();
            if (acc) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic idle0(input int cycles);
        io0.in_valid = 1'b0;
        for (int k = 0; k < cycles; k++) cycle();
    endtask

    task automatic want(input int v, input bit l);
        want_v.push_back(v);
        want_l.push_back(l);
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, got_v.size(), want_v.size());
        for (int i = 0; i < want_v.size() && i < got_v.size(); i++) begin
            chk({tag, "_data"}, got_v[i], want_v[i]);
            chk({tag, "_last"}, int'(got_l[i]), int'(want_l[i]));
        end
        got_v.delete(); got_l.delete(); want_v.delete(); want_l.delete();
    endtask

    task automatic ramp0(input int base);
        for (int i = 0; i < 16; i++) send0(base + i);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent, cyc;
        bit acc;
        rst_n = 1'b0;
        io0.in_valid = 1'b0; io0.in_data = '0; io0.out_ready = 1'b1;
        io1.in_valid = 1'b0; io1.in_data = '0; io1.out_ready = 1'b1;
        cycle(); cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(io0.out_valid), 0);
        chk("rst_out_data", int'(io0.out_data), 0);
        chk("rst_out_last", int'(io0.out_last), 0);
        chk("rst_in_ready", int'(io0.in_ready), 1);
        cycle();

        // Ramp frame
        ramp0(0);
        idle0(3);
        want(5, 0); want(7, 0); want(13, 0); want(15, 1);
        check_got("t1_ramp");

        // Signed extremes
        send0(-256); send0(255); send0(-5); send0(-3);
        send0(-1);   send0(0);   send0(-7); send0(-4);
        send0(10); send0(20); send0(30); send0(40);
        send0(50); send0(60); send0(70); send0(80);
        idle0(3);
        want(255, 0); want(-3, 0); want(60, 0); want(80, 1);
        check_got("t2_signed");

        // Backpressure at the first output
        for (int i = 0; i < 6; i++) send0(i);
        fork
            begin
                io0.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("t3_in_ready_low", int'(io0.in_ready), 0);
                    chk("t3_hold_data", int'(io0.out_data), 5);
                    chk("t3_hold_valid", int'(io0.out_valid), 1);
                    cycle();
                end
                io0.out_ready = 1'b1;
            end
        join_none
        for (int i = 6; i < 16; i++) send0(i);
        idle0(3);
        want(5, 0); want(7, 0); want(13, 0); want(15, 1);
        check_got("t3_backpressure");

        // Back-to-back frames
        ramp0(0);
        ramp0(100);
        idle0(3);
        want(5, 0);   want(7, 0);   want(13, 0);  want(15, 1);
        want(105, 0); want(107, 0); want(113, 0); want(115, 1);
        check_got("t4_b2b");

        // Reset mid-frame
        for (int i = 0; i < 9; i++) send0(i);
        io0.in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_out_valid", int'(io0.out_valid), 0);
        chk("t5_in_ready", int'(io0.in_ready), 1);
        cycle();
        got_v.delete(); got_l.delete();
        ramp0(0);
        idle0(3);
        want(5, 0); want(7, 0); want(13, 0); want(15, 1);
        check_got("t5_reset");

        // Random gaps on the 28x28 instance
        sent = 0;
        cyc  = 0;
        outs[1] = 0;
        while (sent < NPIX && cyc < 200000) begin
            if (!io1.in_valid && $urandom_range(0, 3) != 0) begin
                io1.in_valid = 1'b1;
                io1.in_data  = 9'($urandom_range(0, 511));
            end
            io1.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = io1.in_valid && io1.in_ready;
            cycle();
            cyc++;
            if (acc) begin
                sent++;
                io1.in_valid = 1'b0;
            end
        end
        chk("t6_budget", sent, NPIX);
        io1.in_valid  = 1'b0;
        io1.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        chk("t6_out_count", outs[1], NFRAMES * 196);
        chk("t6_pending", expq[1].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
